poly_mult_sequencer: RTL and testbench

//  Job controller for the parallel polynomial-multiplier datapath (2N-1 addition columns).
//  Per job it loads N coefficient pairs from an external operand SRAM and holds them on the datapath.
//  It pulses a launch strobe and waits out the fixed pipeline latency, then captures all 2N-1 c-values.
//  It streams the c-values out over a valid/ready interface. Sits between the HE job dispatcher and the multiplier array.

---
 rtl/poly_mult_pkg.sv | 17 +
 rtl/poly_mult_sequencer_result_serializer.sv | 66 ++++++
 rtl/poly_mult_sequencer.sv | 161 ++++++++++++++++
 tb/tb_poly_mult_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_mult_pkg.sv
// Shared types and default sizing for the polynomial-multiplier job sequencer.
package poly_mult_pkg;

    localparam int DEFAULT_N_COEFFS    = 8;
    localparam int DEFAULT_COEFF_WIDTH = 8;
    localparam int DEFAULT_MULT_LAT    = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH  = 3'd2,
        LAUNCH = 3'd3,
        WAIT   = 3'd4,
        DRAIN  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/poly_mult_sequencer_result_serializer.sv
// Captures all datapath columns in one cycle, then streams them out in index order.
module result_serializer #(
    parameter  int NC = 15,
    parameter  int W  = 8,
    localparam int IW = $clog2(NC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          capture,
    input  logic [NC*W-1:0] cap_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          done
);

    logic [NC*W-1:0] res_q, res_d;
    logic            valid_q, valid_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            at_end;
    logic            fire;

    // A beat transfers when out_valid && out_ready at a clock edge; once valid is
    // raised, data/idx/last hold until that transfer happens.
    assign at_end = (idx_q == IW'(NC - 1));
    assign fire   = valid_q && out_ready;

    always_comb begin
        res_d   = res_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        if (capture) begin
            res_d   = cap_data;
            valid_d = 1'b1;
            idx_d   = '0;
        end else if (fire) begin
            if (at_end) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = res_q[idx_q*W +: W];
    assign out_idx   = idx_q;
    assign out_last  = valid_q && at_end;
    assign done      = fire && at_end;

endmodule

// File: rtl/poly_mult_sequencer.sv
// Job controller: loads operands from SRAM, launches the multiplier array,
// waits out its latency, then streams the 2N-1 column results.
module poly_mult_sequencer
    import poly_mult_pkg::*;
#(
    parameter  int N_COEFFS    = DEFAULT_N_COEFFS,
    parameter  int COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
    parameter  int MULT_LAT    = DEFAULT_MULT_LAT,
    localparam int NC = 2 * N_COEFFS - 1,
    localparam int AW = $clog2(N_COEFFS),
    localparam int IW = $clog2(NC),
    localparam int LW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_valid,
    output logic                      start_ready,
    output logic                      rd_en,
    output logic [AW-1:0]             rd_addr,
    input  logic [COEFF_WIDTH-1:0]    rd_a,
    input  logic [COEFF_WIDTH-1:0]    rd_b,
    output logic [N_COEFFS*COEFF_WIDTH-1:0] dp_a,
    output logic [N_COEFFS*COEFF_WIDTH-1:0] dp_b,
    output logic                      dp_launch,
    input  logic [NC*COEFF_WIDTH-1:0] dp_c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COEFF_WIDTH-1:0]    out_data,
    output logic [IW-1:0]             out_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic [2:0]                state_dbg
);

    seq_state_e state_q, state_d;
    logic start_ready_q, start_ready_d;
    logic busy_q, busy_d;
    logic rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic rd_vld_q, rd_vld_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic dp_launch_q, dp_launch_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [N_COEFFS*COEFF_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic capture;
    logic drain_done;

    // dp_c is valid exactly in the last WAIT cycle; it is captured at that edge.
    assign capture = (state_q == WAIT) && (lat_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        start_ready_d = start_ready_q;
        busy_d        = busy_q;
        rd_en_d       = rd_en_q;
        rd_addr_d     = rd_addr_q;
        dp_launch_d   = 1'b0;
        lat_cnt_d     = lat_cnt_q;
        rd_vld_d      = rd_en_q;
        wr_addr_d     = rd_addr_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        if (rd_vld_q) begin
            op_a_d[wr_addr_q*COEFF_WIDTH +: COEFF_WIDTH] = rd_a;
            op_b_d[wr_addr_q*COEFF_WIDTH +: COEFF_WIDTH] = rd_b;
        end
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d       = LOAD;
                    start_ready_d = 1'b0;
                    busy_d        = 1'b1;
                    rd_en_d       = 1'b1;
                    rd_addr_d     = '0;
                end
            end
            LOAD: begin
                if (rd_addr_q == AW'(N_COEFFS - 1)) begin
                    state_d = FLUSH;
                    rd_en_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d     = LAUNCH;
                dp_launch_d = 1'b1;
            end
            LAUNCH: begin
                state_d   = WAIT;
                lat_cnt_d = LW'(MULT_LAT - 1);
            end
            WAIT: begin
                if (capture) state_d = DRAIN;
                else         lat_cnt_d = lat_cnt_q - 1'b1;
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d       = IDLE;
                    start_ready_d = 1'b1;
                    busy_d        = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_vld_q      <= 1'b0;
            wr_addr_q     <= '0;
            dp_launch_q   <= 1'b0;
            lat_cnt_q     <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
        end else begin
            state_q       <= state_d;
            start_ready_q <= start_ready_d;
            busy_q        <= busy_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_vld_q      <= rd_vld_d;
            wr_addr_q     <= wr_addr_d;
            dp_launch_q   <= dp_launch_d;
            lat_cnt_q     <= lat_cnt_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
        end
    end

    result_serializer #(
        .NC (NC),
        .W  (COEFF_WIDTH)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .cap_data  (dp_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (drain_done)
    );

    assign start_ready = start_ready_q;
    assign busy        = busy_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign dp_launch   = dp_launch_q;
    assign dp_a        = op_a_q;
    assign dp_b        = op_b_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_poly_mult_sequencer.sv
// Bench for poly_mult_sequencer: SRAM and multiplier-array models plus a result scoreboard.
module tb_poly_mult_sequencer;

    localparam int N   = 8;
    localparam int W   = 8;
    localparam int LAT = 4;
    localparam int NC  = 2 * N - 1;
    localparam int AW  = $clog2(N);
    localparam int IW  = $clog2(NC);
    localparam int EW  = 1 + IW + W;

    logic clk = 1'b0;
    logic reset;
    logic start_valid, start_ready;
    logic rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0] rd_a, rd_b;
    logic [N*W-1:0] dp_a, dp_b;
    logic dp_launch;
    logic [NC*W-1:0] dp_c;
    logic out_valid, out_ready;
    logic [W-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic out_last, busy;
    logic [2:0] state_dbg;

    poly_mult_sequencer #(.N_COEFFS(N), .COEFF_WIDTH(W), .MULT_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_launch(dp_launch), .dp_c(dp_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / cycle counter
    initial forever #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];
    logic [W-1:0] mem_a[N];
    logic [W-1:0] mem_b[N];
    int t2[NC] = '{1, 3, 6, 10, 15, 21, 28, 36, 35, 33, 30, 26, 21, 15, 8};
    int ready_mode = 0;
    int acc_cyc = 0, acc_cnt = 0, last_hs_cyc = 0;
    bit job_live = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NC*W-1:0] conv(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [NC*W-1:0] c;
        logic [W-1:0] s;
        int p;
        c = '0;
        for (int k = 0; k < NC; k++) begin
            s = '0;
            for (int i = 0; i < N; i++) begin
                if (k - i >= 0 && k - i < N) begin
                    p = int'(a[i*W +: W]) * int'(b[(k-i)*W +: W]);
                    s = s + p[W-1:0];
                end
            end
            c[k*W +: W] = s;
        end
        return c;
    endfunction

    // operand SRAM: registered read
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
    end

    // multiplier array: result valid LAT cycles after launch, junk otherwise
    logic [NC*W-1:0] pipe[LAT];
    always @(posedge clk) begin
        pipe[0] <= dp_launch ? conv(dp_a, dp_b) : {NC{8'hA5}};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign dp_c = pipe[LAT-1];

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor / scoreboard
    initial begin
        logic prev_launch, prev_valid, prev_busy, launched, stalled;
        logic [2*N*W-1:0] saved;
        logic [EW:0] held;
        logic [EW-1:0] e;
        prev_launch = 0; prev_valid = 0; prev_busy = 0; launched = 0; stalled = 0;
        saved = '0; held = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_busy && !busy && job_live) begin
                    if (ready_mode == 0) check("busy_cycles", cyc - acc_cyc, N + 3 + LAT + NC);
                    job_live = 0;
                end
                if (!busy) launched = 0;
                if (start_valid && start_ready) begin
                    acc_cyc = cyc;
                    acc_cnt++;
                    job_live = 1;
                end
                if (prev_launch) check("launch_width", dp_launch, 0);
                if (dp_launch && !prev_launch) begin
                    check("launch_cyc", cyc - acc_cyc, N + 2);
                    saved = {dp_a, dp_b};
                    launched = 1;
                end else if (launched && busy) begin
                    check("dp_hold", ({dp_a, dp_b} == saved), 1);
                end
                if (out_valid && !prev_valid && job_live)
                    check("first_valid", cyc - acc_cyc, N + 3 + LAT);
                if (stalled) check("stall_hold", {out_valid, out_last, out_idx, out_data}, held);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {out_last, out_idx, out_data}, e);
                    end
                    if (out_last) last_hs_cyc = cyc;
                end
            end
            prev_launch = dp_launch;
            prev_valid  = out_valid;
            prev_busy   = busy;
            stalled     = !reset && out_valid && !out_ready;
            held        = {out_valid, out_last, out_idx, out_data};
        end
    end

    task automatic push_conv();
        logic [N*W-1:0] a, b;
        logic [NC*W-1:0] c;
        for (int i = 0; i < N; i++) begin
            a[i*W +: W] = mem_a[i];
            b[i*W +: W] = mem_b[i];
        end
        c = conv(a, b);
        for (int k = 0; k < NC; k++) exp_q.push_back({1'(k == NC - 1), IW'(k), c[k*W +: W]});
    endtask

    task automatic push_table();
        for (int k = 0; k < NC; k++) exp_q.push_back({1'(k == NC - 1), IW'(k), W'(t2[k])});
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            mem_a[i] = W'($urandom_range(0, 255));
            mem_b[i] = W'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        check("job_done", ok, 1);
    endtask

    task automatic run_job();
        int n0;
        n0 = acc_cnt;
        @(posedge clk);
        #1 start_valid = 1'b1;
        for (int i = 0; i < 20 && acc_cnt == n0; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 start_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n0;
        reset = 1'b1;
        start_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_launch", dp_launch, 0);
        check("rst_dp_a", dp_a, 0);
        check("rst_state", state_dbg, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // abort mid-LOAD
        fill_random();
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("load_rd_en", rd_en, 1);
        check("load_rd_addr", rd_addr, 2);
        check("load_start_ready", start_ready, 0);
        @(posedge clk);
        #1 job_live = 0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_start_ready", start_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_state", state_dbg, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ramp times ones, free-flowing then stalled output
        for (int i = 0; i < N; i++) begin
            mem_a[i] = W'(i + 1);
            mem_b[i] = 8'd1;
        end
        ready_mode = 0;
        push_table();
        run_job();
        ready_mode = 1;
        push_table();
        run_job();

        // all-ones operands: products wrap inside the datapath
        ready_mode = 0;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
        push_conv();
        run_job();

        // start_valid held high across two jobs
        fill_random();
        push_conv();
        push_conv();
        n0 = acc_cnt;
        @(posedge clk);
        #1 start_valid = 1'b1;
        for (int i = 0; i < 200 && acc_cnt < n0 + 2; i++) begin
            @(negedge clk);
            #1;
        end
        check("b2b_gap", acc_cyc - last_hs_cyc, 1);
        @(posedge clk);
        #1 start_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        check("accept_count", acc_cnt - n0, 2);

        // random operands with random backpressure
        ready_mode = 2;
        for (int j = 0; j < 3; j++) begin
            fill_random();
            push_conv();
            run_job();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
